// File: rtl/cache_control.sv
// Control FSM for a 2-way set-associative L1 data cache: hit handling, write-back and
// line allocation sequencing, plus saturating hit/miss/write-back event counters.
module cache_control #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_mem_read,
  input  logic             i_mem_write,
  output logic             o_mem_resp,
  input  logic             i_hit1,
  input  logic             i_hit2,
  input  logic             i_dirty1,
  input  logic             i_dirty2,
  input  logic             i_lru,
  output logic             o_load_lru,
  output logic             o_lru_in,
  output logic [1:0]       o_load_way,
  output logic             o_set_valid,
  output logic             o_set_dirty,
  output logic             o_data_sel,
  output logic             o_pmem_addr_sel,
  output logic             o_victim,
  output logic             o_pmem_read,
  output logic             o_pmem_write,
  input  logic             i_pmem_resp,
  output logic [CNT_W-1:0] o_hit_cnt,
  output logic [CNT_W-1:0] o_miss_cnt,
  output logic [CNT_W-1:0] o_wb_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMPARE   = 2'd1,
    ST_WRITEBACK = 2'd2,
    ST_ALLOCATE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_victim;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;
  logic [CNT_W-1:0] r_wb_cnt;

  logic w_req;
  logic w_hit;
  logic w_victim_dirty;
  logic w_hit_evt;
  logic w_miss_evt;
  logic w_wb_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  assign w_req          = i_mem_read | i_mem_write;
  assign w_hit          = i_hit1 | i_hit2;
  // Victim dirtiness is judged on the incoming LRU, since the victim register is written this same edge.
  assign w_victim_dirty = i_lru ? i_dirty2 : i_dirty1;

  // State register and latched victim way.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_victim <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_miss_evt) begin
        r_victim <= i_lru;
      end else begin
        r_victim <= r_victim;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hit_cnt  <= {CNT_W{1'b0}};
      r_miss_cnt <= {CNT_W{1'b0}};
      r_wb_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_hit_cnt  <= w_hit_evt  ? sat_inc(r_hit_cnt)  : r_hit_cnt;
      r_miss_cnt <= w_miss_evt ? sat_inc(r_miss_cnt) : r_miss_cnt;
      r_wb_cnt   <= w_wb_evt   ? sat_inc(r_wb_cnt)   : r_wb_cnt;
    end
  end

  // Next-state and array/pmem control decode.
  always_comb begin
    w_state_next    = r_state;
    o_mem_resp      = 1'b0;
    o_load_lru      = 1'b0;
    o_lru_in        = 1'b0;
    o_load_way      = 2'b00;
    o_set_valid     = 1'b0;
    o_set_dirty     = 1'b0;
    o_data_sel      = 1'b0;
    o_pmem_addr_sel = 1'b0;
    o_pmem_read     = 1'b0;
    o_pmem_write    = 1'b0;
    w_hit_evt       = 1'b0;
    w_miss_evt      = 1'b0;
    w_wb_evt        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_state_next = ST_COMPARE;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_COMPARE: begin
        if (!w_req) begin
          w_state_next = ST_IDLE;
        end else if (w_hit) begin
          // Way 1 takes priority; LRU then points at the way not just used.
          o_mem_resp   = 1'b1;
          o_load_lru   = 1'b1;
          o_lru_in     = i_hit1 ? 1'b1 : 1'b0;
          w_hit_evt    = 1'b1;
          w_state_next = ST_IDLE;
          if (i_mem_write) begin
            o_load_way  = i_hit1 ? 2'b01 : 2'b10;
            o_data_sel  = 1'b0;
            o_set_dirty = 1'b1;
          end else begin
            o_load_way  = 2'b00;
          end
        end else begin
          w_miss_evt = 1'b1;
          if (w_victim_dirty) begin
            w_state_next = ST_WRITEBACK;
          end else begin
            w_state_next = ST_ALLOCATE;
          end
        end
      end
      ST_WRITEBACK: begin
        o_pmem_write    = 1'b1;
        o_pmem_addr_sel = 1'b1;
        if (i_pmem_resp) begin
          w_wb_evt     = 1'b1;
          w_state_next = ST_ALLOCATE;
        end else begin
          w_state_next = ST_WRITEBACK;
        end
      end
      ST_ALLOCATE: begin
        o_pmem_read = 1'b1;
        if (i_pmem_resp) begin
          o_load_way   = r_victim ? 2'b10 : 2'b01;
          o_data_sel   = 1'b1;
          o_set_valid  = 1'b1;
          o_set_dirty  = 1'b0;
          w_state_next = ST_COMPARE;
        end else begin
          w_state_next = ST_ALLOCATE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign o_victim   = r_victim;
  assign o_hit_cnt  = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;
  assign o_wb_cnt   = r_wb_cnt;

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: expected hit responses are queued at request time and
// checked when mem_resp pulses; a CNT_W=2 instance shares the stimulus to exercise saturation.
module tb_cache_control;

  logic clk = 1'b0;
  logic rst_n, mem_read, mem_write, hit1, hit2, dirty1, dirty2, lru, pmem_resp;
  logic mem_resp, load_lru, lru_in, set_valid, set_dirty, data_sel, pmem_addr_sel;
  logic victim, pmem_read, pmem_write;
  logic [1:0]  load_way;
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;

  logic s_mem_resp, s_load_lru, s_lru_in, s_set_valid, s_set_dirty, s_data_sel;
  logic s_pmem_addr_sel, s_victim, s_pmem_read, s_pmem_write;
  logic [1:0] s_load_way;
  logic [1:0] s_hit_cnt, s_miss_cnt, s_wb_cnt;

  int total = 0;
  int bad = 0;
  int resp_seen = 0;

  typedef struct packed {
    logic [1:0] lw;
    logic       sd;
    logic       ds;
    logic       lin;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  cache_control #(.CNT_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_read(mem_read), .i_mem_write(mem_write),
    .o_mem_resp(mem_resp), .i_hit1(hit1), .i_hit2(hit2), .i_dirty1(dirty1), .i_dirty2(dirty2),
    .i_lru(lru), .o_load_lru(load_lru), .o_lru_in(lru_in), .o_load_way(load_way),
    .o_set_valid(set_valid), .o_set_dirty(set_dirty), .o_data_sel(data_sel),
    .o_pmem_addr_sel(pmem_addr_sel), .o_victim(victim), .o_pmem_read(pmem_read),
    .o_pmem_write(pmem_write), .i_pmem_resp(pmem_resp),
    .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt), .o_wb_cnt(wb_cnt)
  );

  cache_control #(.CNT_W(2)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_read(mem_read), .i_mem_write(mem_write),
    .o_mem_resp(s_mem_resp), .i_hit1(hit1), .i_hit2(hit2), .i_dirty1(dirty1), .i_dirty2(dirty2),
    .i_lru(lru), .o_load_lru(s_load_lru), .o_lru_in(s_lru_in), .o_load_way(s_load_way),
    .o_set_valid(s_set_valid), .o_set_dirty(s_set_dirty), .o_data_sel(s_data_sel),
    .o_pmem_addr_sel(s_pmem_addr_sel), .o_victim(s_victim), .o_pmem_read(s_pmem_read),
    .o_pmem_write(s_pmem_write), .i_pmem_resp(pmem_resp),
    .o_hit_cnt(s_hit_cnt), .o_miss_cnt(s_miss_cnt), .o_wb_cnt(s_wb_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read = 1'b0; mem_write = 1'b0; hit1 = 1'b0; hit2 = 1'b0;
    dirty1 = 1'b0; dirty2 = 1'b0; lru = 1'b0; pmem_resp = 1'b0;
  endtask

  // Response scoreboard: every mem_resp must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_resp === 1'b1) begin
      exp_t e;
      resp_seen++;
      if (q.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("resp_load_way", {30'd0, load_way}, {30'd0, e.lw});
        check("resp_set_dirty", {31'd0, set_dirty}, {31'd0, e.sd});
        check("resp_data_sel", {31'd0, data_sel}, {31'd0, e.ds});
        check("resp_lru_in", {31'd0, lru_in}, {31'd0, e.lin});
        check("resp_load_lru", {31'd0, load_lru}, 32'd1);
        check("resp_set_valid", {31'd0, set_valid}, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    idle_inputs();
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mem_resp", {31'd0, mem_resp}, 32'd0);
    check("rst_pmem", {30'd0, pmem_read, pmem_write}, 32'd0);
    check("rst_load_way", {30'd0, load_way}, 32'd0);
    check("rst_victim", {31'd0, victim}, 32'd0);
    check("rst_cnts", hit_cnt | miss_cnt | wb_cnt, 32'd0);

    // 1: read hit way 1
    cyc();
    r0 = resp_seen;
    mem_read = 1'b1; hit1 = 1'b1;
    q.push_back('{lw: 2'b00, sd: 1'b0, ds: 1'b0, lin: 1'b1});
    @(negedge clk);
    check("t1_no_resp_cycle1", {31'd0, mem_resp}, 32'd0);
    cyc();
    @(negedge clk);
    check("t1_resp_cycle2", {31'd0, mem_resp}, 32'd1);
    cyc();
    idle_inputs();
    @(negedge clk);
    check("t1_hit_cnt", hit_cnt, 32'd1);
    check("t1_one_resp", resp_seen - r0, 32'd1);

    // 2: write hit way 2
    cyc();
    mem_write = 1'b1; hit2 = 1'b1;
    q.push_back('{lw: 2'b10, sd: 1'b1, ds: 1'b0, lin: 1'b0});
    cyc();
    @(negedge clk);
    check("t2_resp_cycle2", {31'd0, mem_resp}, 32'd1);
    cyc();
    idle_inputs();
    @(negedge clk);
    check("t2_hit_cnt", hit_cnt, 32'd2);

    // 3: clean read miss, lru = 1, pmem latency 5
    cyc();
    r0 = resp_seen;
    mem_read = 1'b1; lru = 1'b1;
    cyc();
    @(negedge clk);
    check("t3_compare_no_resp", {31'd0, mem_resp}, 32'd0);
    check("t3_compare_no_pmem", {31'd0, pmem_read}, 32'd0);
    cyc();
    lru = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pmem_resp = (i == 4);
      @(negedge clk);
      check("t3_pmem_read", {31'd0, pmem_read}, 32'd1);
      check("t3_addr_sel", {31'd0, pmem_addr_sel}, 32'd0);
      check("t3_victim", {31'd0, victim}, 32'd1);
      check("t3_load_way", {30'd0, load_way}, (i == 4) ? 32'd2 : 32'd0);
      check("t3_set_valid", {31'd0, set_valid}, (i == 4) ? 32'd1 : 32'd0);
      check("t3_data_sel", {31'd0, data_sel}, (i == 4) ? 32'd1 : 32'd0);
      cyc();
    end
    pmem_resp = 1'b0; hit2 = 1'b1;
    q.push_back('{lw: 2'b00, sd: 1'b0, ds: 1'b0, lin: 1'b0});
    @(negedge clk);
    check("t3_resp_after_fill", {31'd0, mem_resp}, 32'd1);
    check("t3_pmem_dropped", {31'd0, pmem_read}, 32'd0);
    cyc();
    idle_inputs();
    @(negedge clk);
    check("t3_miss_cnt", miss_cnt, 32'd1);
    check("t3_wb_cnt", wb_cnt, 32'd0);
    check("t3_one_resp", resp_seen - r0, 32'd1);

    // 4: dirty write miss, lru = 0, dirty1 = 1; write-back latency 3, fill latency 2
    cyc();
    r0 = resp_seen;
    mem_write = 1'b1; dirty1 = 1'b1;
    cyc();
    cyc();
    for (int i = 0; i < 3; i++) begin
      pmem_resp = (i == 2);
      @(negedge clk);
      check("t4_pmem_write", {31'd0, pmem_write}, 32'd1);
      check("t4_wb_addr_sel", {31'd0, pmem_addr_sel}, 32'd1);
      check("t4_wb_no_read", {31'd0, pmem_read}, 32'd0);
      check("t4_victim", {31'd0, victim}, 32'd0);
      check("t4_wb_no_load", {30'd0, load_way}, 32'd0);
      cyc();
    end
    dirty1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pmem_resp = (i == 1);
      @(negedge clk);
      check("t4_pmem_read", {30'd0, pmem_read, pmem_write}, 32'd2);
      check("t4_fill_addr_sel", {31'd0, pmem_addr_sel}, 32'd0);
      check("t4_fill_load_way", {30'd0, load_way}, (i == 1) ? 32'd1 : 32'd0);
      cyc();
    end
    pmem_resp = 1'b0; hit1 = 1'b1;
    q.push_back('{lw: 2'b01, sd: 1'b1, ds: 1'b0, lin: 1'b1});
    cyc();
    idle_inputs();
    @(negedge clk);
    check("t4_wb_cnt", wb_cnt, 32'd1);
    check("t4_miss_cnt", miss_cnt, 32'd2);
    check("t4_one_resp", resp_seen - r0, 32'd1);

    // 5: reset asserted while in ALLOCATE
    cyc();
    r0 = resp_seen;
    mem_read = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    check("t5_alloc_pmem_read", {31'd0, pmem_read}, 32'd1);
    cyc();
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_no_load_in_rst_cycle", {30'd0, load_way}, 32'd0);
    cyc();
    @(negedge clk);
    check("t5_pmem_read_dropped", {31'd0, pmem_read}, 32'd0);
    check("t5_no_load_way", {30'd0, load_way}, 32'd0);
    check("t5_cnts_cleared", hit_cnt | miss_cnt | wb_cnt, 32'd0);
    check("t5_victim", {31'd0, victim}, 32'd0);
    cyc();
    idle_inputs();
    rst_n = 1'b1;
    cyc();
    @(negedge clk);
    check("t5_no_resp", resp_seen - r0, 32'd0);

    // 6: five read hits; the CNT_W=2 copy saturates at 3
    for (int n = 1; n <= 5; n++) begin
      cyc();
      mem_read = 1'b1; hit1 = 1'b1;
      q.push_back('{lw: 2'b00, sd: 1'b0, ds: 1'b0, lin: 1'b1});
      cyc();
      cyc();
      idle_inputs();
      @(negedge clk);
      check("t6_hit_cnt", hit_cnt, n);
      check("t6_sat_hit_cnt", {30'd0, s_hit_cnt}, (n > 3) ? 32'd3 : n);
    end

    // 7: read and write together act as a write; way 1 wins when both hit
    cyc();
    mem_read = 1'b1; mem_write = 1'b1; hit1 = 1'b1; hit2 = 1'b1;
    q.push_back('{lw: 2'b01, sd: 1'b1, ds: 1'b0, lin: 1'b1});
    cyc();
    cyc();
    idle_inputs();

    // 8: request dropped in COMPARE gives no response and no array writes
    cyc();
    r0 = resp_seen;
    mem_read = 1'b1; hit2 = 1'b1;
    cyc();
    idle_inputs();
    @(negedge clk);
    check("t8_no_resp", {31'd0, mem_resp}, 32'd0);
    check("t8_no_lru", {31'd0, load_lru}, 32'd0);
    cyc();
    @(negedge clk);
    check("t8_hit_cnt_same", hit_cnt, 32'd6);
    check("t8_resp_count", resp_seen - r0, 32'd0);
    check("queue_drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
